// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction fetch stage. Holds the architectural PC, returns PC+4 to the
// next-PC mux, reloads the PC from the mux output (pc_now) when a fetch
// completes, drives a req/ready instruction-memory handshake and loads the
// IF/ID pipeline register. Handles load-use stall (stall_IF) and jump/branch
// squash (redirect). Redirect takes priority over stall everywhere.
//
// Optional feature macro: FETCH_PERF_EN
//   When defined, adds the free-running performance counters fetch_cnt
//   (valid instructions written to IF/ID) and stall_cnt (cycles with
//   stall_IF=1). When undefined, those ports do not exist.
//
// Ports
//   clk         in   1   clock, rising edge
//   rst_n       in   1   synchronous reset, active-low
//   pc_now      in   32  next PC from the next-PC mux
//   redirect    in   1   jump/branch taken (squash + retarget)
//   stall_IF    in   1   hazard stall: hold IF/ID, start no new fetch
//   pc_out_IF   out  32  PC+4 (combinational) to next-PC mux
//   pc_IF       out  32  current PC register
//   imem_req    out  1   fetch request
//   imem_addr   out  32  fetch address (= pc_IF)
//   imem_ready  in   1   transfer completes when imem_req && imem_ready
//   imem_rdata  in   32  fetched instruction, valid on the ready cycle
//   inst_ID     out  32  IF/ID instruction
//   pc_ID       out  32  IF/ID PC of inst_ID
//   valid_ID    out  1   IF/ID slot holds a valid, non-squashed instruction
//   fetch_cnt   out  32  (FETCH_PERF_EN only) valid fetch count
//   stall_cnt   out  32  (FETCH_PERF_EN only) stall cycle count
// ---------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_now,
    input  logic        redirect,
    input  logic        stall_IF,
    output logic [31:0] pc_out_IF,
    output logic [31:0] pc_IF,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_ID,
    output logic [31:0] pc_ID,
    output logic        valid_ID
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
`endif
);

    // IDLE : first cycle out of reset, no request
    // REQ  : request outstanding at pc_p0
    // DROP : squashed request still in flight, its data will be thrown away
    // HELD : completed instruction parked in the hold buffer during a stall
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2,
        HELD = 2'd3
    } state_t;

    state_t      state;
    logic        req_q;
    logic [31:0] pc_p0;
    logic [31:0] target_pc_p0;
    logic [31:0] hold_inst_p1;
    logic [31:0] hold_pc_p1;
    logic [31:0] inst_p1;
    logic [31:0] pc_id_p1;
    logic        vld_p1;
    logic        fetch_fire;

    assign pc_out_IF = pc_p0 + 32'd4;
    assign pc_IF     = pc_p0;
    assign imem_addr = pc_p0;
    assign imem_req  = req_q;
    assign inst_ID   = inst_p1;
    assign pc_ID     = pc_id_p1;
    assign valid_ID  = vld_p1;

    // A valid instruction enters IF/ID either straight from memory or from
    // the hold buffer once the stall releases.
    assign fetch_fire = !redirect && !stall_IF &&
                        (((state == REQ) && imem_ready) || (state == HELD));

    // ---- stage p0 (PC / request) -> stage p1 (IF/ID register) ----
    // The hold buffer and redirect target carry no reset: their contents are
    // only read in the states that wrote them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            req_q    <= 1'b0;
            pc_p0    <= RESET_PC;
            inst_p1  <= NOP_INST;
            pc_id_p1 <= 32'd0;
            vld_p1   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                    req_q <= 1'b1;
                end

                REQ: begin
                    if (imem_ready) begin
                        pc_p0 <= pc_now;
                        if (redirect) begin
                            vld_p1 <= 1'b0;
                        end else if (stall_IF) begin
                            hold_inst_p1 <= imem_rdata;
                            hold_pc_p1   <= pc_p0;
                            state        <= HELD;
                            req_q        <= 1'b0;
                        end else begin
                            inst_p1  <= imem_rdata;
                            pc_id_p1 <= pc_p0;
                            vld_p1   <= 1'b1;
                        end
                    end else if (redirect) begin
                        // Request cannot be withdrawn; let it finish and
                        // remember where to go afterwards.
                        target_pc_p0 <= pc_now;
                        state        <= DROP;
                        vld_p1       <= 1'b0;
                    end else if (!stall_IF) begin
                        vld_p1 <= 1'b0;
                    end
                end

                DROP: begin
                    vld_p1 <= 1'b0;
                    if (imem_ready) begin
                        // A redirect on the completion edge is the newest target.
                        pc_p0 <= redirect ? pc_now : target_pc_p0;
                        state <= REQ;
                    end else if (redirect) begin
                        target_pc_p0 <= pc_now;
                    end
                end

                HELD: begin
                    if (redirect) begin
                        pc_p0  <= pc_now;
                        vld_p1 <= 1'b0;
                        state  <= REQ;
                        req_q  <= 1'b1;
                    end else if (!stall_IF) begin
                        inst_p1  <= hold_inst_p1;
                        pc_id_p1 <= hold_pc_p1;
                        vld_p1   <= 1'b1;
                        state    <= REQ;
                        req_q    <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if (fetch_fire) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall_IF)   stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end
`else
    logic unused_fetch_fire;
    assign unused_fetch_fire = fetch_fire;
`endif

endmodule
